if_redirect_ctrl: RTL and testbench

- Sequences every control-flow redirect into the dual-issue fetch stage: branch, j and jr targets, exception entry and eret.
- Resolves delay-slot timing for a branch in slot 1 versus slot 2, and holds a jr until its register data is ready.
- Sits between the ID/EX redirect sources and the IF stage.
- Presents one registered redirect (PC plus flush) that stays stable across IF stalls until IF consumes it.

---
 rtl/if_redirect_ctrl_pkg.sv | 18 +
 rtl/if_redirect_ctrl_if.sv | 34 +++
 rtl/if_redirect_ctrl.sv | 144 ++++++++++++++
 tb/tb_if_redirect_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_redirect_ctrl_pkg.sv
// rtl/if_redirect_ctrl_pkg.sv - shared redirect state encoding, reset/exception vectors and slot codes
package if_redirect_ctrl_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'hBFC0_0000;
    localparam logic [31:0] EXC_VEC_DEF  = 32'hBFC0_0380;

    // Slot of the redirecting instruction within the fetched pair
    localparam logic SLOT_1 = 1'b0;
    localparam logic SLOT_2 = 1'b1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SLOT_WAIT = 2'd1,
        DATA_WAIT = 2'd2,
        ISSUE     = 2'd3
    } redir_state_t;

endpackage

// File: rtl/if_redirect_ctrl_if.sv
// rtl/if_redirect_ctrl_if.sv - redirect source / IF handshake bundle for if_redirect_ctrl
interface if_redirect_ctrl_if #(
    parameter int PC_W = 32
);
    logic            if_stall;
    logic            fetch_fire;
    logic            exc_req;
    logic            eret_req;
    logic [PC_W-1:0] epc;
    logic            br_valid;
    logic            br_slot;
    logic [PC_W-1:0] br_target;
    logic            jr_req;
    logic            jr_slot;
    logic            jr_data_ok;
    logic [PC_W-1:0] jr_data;
    logic            redirect_valid;
    logic [PC_W-1:0] redirect_pc;
    logic            flush_if;
    logic            busy;
    logic            adel_req;

    modport slave (
        input  if_stall, fetch_fire, exc_req, eret_req, epc,
        input  br_valid, br_slot, br_target, jr_req, jr_slot, jr_data_ok, jr_data,
        output redirect_valid, redirect_pc, flush_if, busy, adel_req
    );

    modport master (
        output if_stall, fetch_fire, exc_req, eret_req, epc,
        output br_valid, br_slot, br_target, jr_req, jr_slot, jr_data_ok, jr_data,
        input  redirect_valid, redirect_pc, flush_if, busy, adel_req
    );
endinterface

// File: rtl/if_redirect_ctrl.sv
// rtl/if_redirect_ctrl.sv - sequences branch/jr/exception/eret redirects into IF; IF_REDIRECT_ALIGN_CHECK_EN enables misaligned-target adel_req
module if_redirect_ctrl
    import if_redirect_ctrl_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF),
    parameter logic [PC_W-1:0] EXC_VEC  = PC_W'(EXC_VEC_DEF)
) (
    input  logic                clk,
    input  logic                reset,
    if_redirect_ctrl_if.slave   bus
);

    redir_state_t    r_state;
    logic [PC_W-1:0] r_target;
    logic            r_slot;
    logic            r_ds_fetched;
    logic            r_redirect_valid;
    logic            r_flush_if;
    logic            r_busy;
    logic            r_adel_req;
    logic [PC_W-1:0] r_redirect_pc;

    redir_state_t    w_next;
    logic            w_enter;
    logic [PC_W-1:0] w_enter_pc;
    logic [PC_W-1:0] w_target_d;
    logic            w_slot_d;
    logic            w_ds_d;
    logic            w_adel;
    logic            w_new_req;
    logic [PC_W-1:0] w_new_tgt;
    logic            w_new_slot;

    // A jr with its data already available behaves exactly like a branch; br wins a tie
    assign w_new_req  = bus.br_valid || (bus.jr_req && bus.jr_data_ok);
    assign w_new_tgt  = bus.br_valid ? bus.br_target : bus.jr_data;
    assign w_new_slot = bus.br_valid ? bus.br_slot   : bus.jr_slot;

    always_comb begin
        w_next     = r_state;
        w_enter    = 1'b0;
        w_enter_pc = r_redirect_pc;
        w_target_d = r_target;
        w_slot_d   = r_slot;
        w_ds_d     = r_ds_fetched;
        w_adel     = 1'b0;
        if (bus.exc_req) begin
            w_enter    = 1'b1;
            w_enter_pc = EXC_VEC;
        end else if (bus.eret_req) begin
            w_enter    = 1'b1;
            w_enter_pc = bus.epc;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_new_req) begin
                        w_target_d = w_new_tgt;
                        if (w_new_slot == SLOT_1) begin
                            w_enter    = 1'b1;
                            w_enter_pc = w_new_tgt;
                        end else begin
                            w_next = SLOT_WAIT;
                        end
                    end else if (bus.jr_req) begin
                        w_next   = DATA_WAIT;
                        w_slot_d = bus.jr_slot;
                        w_ds_d   = 1'b0;
                    end
                end
                SLOT_WAIT: begin
                    if (bus.fetch_fire) begin
                        w_enter    = 1'b1;
                        w_enter_pc = r_target;
                    end
                end
                DATA_WAIT: begin
                    // A delay slot fetched in the same cycle the data arrives still counts
                    w_ds_d = r_ds_fetched | bus.fetch_fire;
                    if (bus.jr_data_ok) begin
                        w_target_d = bus.jr_data;
                        if (r_slot == SLOT_1 || w_ds_d) begin
                            w_enter    = 1'b1;
                            w_enter_pc = bus.jr_data;
                        end else begin
                            w_next = SLOT_WAIT;
                        end
                    end
                end
                ISSUE: begin
                    if (!bus.if_stall) begin
                        w_next = IDLE;
                    end
                end
                default: w_next = IDLE;
            endcase
        end
`ifdef IF_REDIRECT_ALIGN_CHECK_EN
        // Only br/jr targets are checked; exception and eret vectors go through untouched
        if (w_enter && !bus.exc_req && !bus.eret_req && (w_enter_pc[1:0] != 2'b00)) begin
            w_enter = 1'b0;
            w_adel  = 1'b1;
        end
`endif
        if (w_enter) begin
            w_next = ISSUE;
        end else if (w_adel) begin
            w_next = IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state          <= IDLE;
            r_target         <= '0;
            r_slot           <= SLOT_1;
            r_ds_fetched     <= 1'b0;
            r_redirect_valid <= 1'b0;
            r_flush_if       <= 1'b0;
            r_busy           <= 1'b0;
            r_adel_req       <= 1'b0;
            r_redirect_pc    <= RESET_PC;
        end else begin
            r_state          <= w_next;
            r_target         <= w_target_d;
            r_slot           <= w_slot_d;
            r_ds_fetched     <= w_ds_d;
            r_redirect_valid <= (w_next == ISSUE);
            r_flush_if       <= (w_next == ISSUE);
            r_busy           <= (w_next != IDLE);
            r_adel_req       <= w_adel;
            if (w_enter) begin
                r_redirect_pc <= w_enter_pc;
            end
        end
    end

    assign bus.redirect_valid = r_redirect_valid;
    assign bus.redirect_pc    = r_redirect_pc;
    assign bus.flush_if       = r_flush_if;
    assign bus.busy           = r_busy;
    assign bus.adel_req       = r_adel_req;

endmodule

// File: tb/tb_if_redirect_ctrl.sv
// tb/tb_if_redirect_ctrl.sv - scoreboard bench for if_redirect_ctrl with directed and random stimulus
module tb_if_redirect_ctrl;

    localparam logic [31:0] RST_PC = 32'hBFC0_0000;
    localparam logic [31:0] EXCV   = 32'hBFC0_0380;

    typedef struct {
        logic        exc;
        logic        eret;
        logic [31:0] epc;
        logic        br;
        logic        bslot;
        logic [31:0] btgt;
        logic        jr;
        logic        jslot;
        logic        jok;
        logic [31:0] jdata;
        logic        ff;
        logic        stall;
    } stim_t;

    typedef struct {
        int          stamp;
        logic [31:0] pc;
    } rd_t;

    typedef struct {
        int   stamp;
        logic busy;
        logic adel;
    } st_t;

    logic clk;
    logic reset;
    int   cyc;
    int   total;
    int   bad;
    bit   run;

    rd_t  rd_q[$];
    st_t  st_q[$];

    // Reference model: what the redirect block owes IF, in terms of pending work
    bit          m_pres;
    bit          m_wslot;
    bit          m_wdata;
    bit          m_need_ds;
    bit          m_ds;
    bit          m_adel;
    logic [31:0] m_tgt;
    logic [31:0] m_pc;

    if_redirect_ctrl_if bus ();

    if_redirect_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic stim_t idle_stim();
        stim_t s;
        s.exc = 0; s.eret = 0; s.epc = '0; s.br = 0; s.bslot = 0; s.btgt = '0;
        s.jr = 0; s.jslot = 0; s.jok = 0; s.jdata = '0; s.ff = 0; s.stall = 0;
        return s;
    endfunction

    function automatic logic [31:0] rand_tgt();
        logic [31:0] t;
        t = $urandom;
        if ($urandom_range(0, 9) != 0) t[1:0] = 2'b00;
        return t;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s       = idle_stim();
        s.exc   = ($urandom_range(0, 99) < 2);
        s.eret  = ($urandom_range(0, 99) < 2);
        s.epc   = rand_tgt();
        s.br    = ($urandom_range(0, 99) < 20);
        s.bslot = 1'($urandom_range(0, 1));
        s.btgt  = rand_tgt();
        s.jr    = ($urandom_range(0, 99) < 15);
        s.jslot = 1'($urandom_range(0, 1));
        s.jok   = ($urandom_range(0, 99) < 35);
        s.jdata = rand_tgt();
        s.ff    = ($urandom_range(0, 99) < 40);
        s.stall = ($urandom_range(0, 99) < 35);
        return s;
    endfunction

    task automatic model_clear();
        m_pres = 0; m_wslot = 0; m_wdata = 0; m_need_ds = 0; m_ds = 0; m_adel = 0;
        m_tgt = '0; m_pc = RST_PC;
    endtask

    task automatic model_step(input stim_t s);
        bit          fire;
        bit          from_tgt;
        logic [31:0] dest;
        logic [31:0] t;
        bit          sl;
        fire = 0; from_tgt = 0; dest = '0; m_adel = 0;
        if (s.exc) begin
            fire = 1; dest = EXCV;
        end else if (s.eret) begin
            fire = 1; dest = s.epc;
        end else if (m_pres) begin
            if (!s.stall) m_pres = 0;
        end else if (m_wdata) begin
            m_ds = m_ds | s.ff;
            if (s.jok) begin
                if (!m_need_ds || m_ds) begin
                    fire = 1; from_tgt = 1; dest = s.jdata;
                end else begin
                    m_wdata = 0; m_wslot = 1; m_tgt = s.jdata;
                end
            end
        end else if (m_wslot) begin
            if (s.ff) begin
                fire = 1; from_tgt = 1; dest = m_tgt;
            end
        end else if (s.br || (s.jr && s.jok)) begin
            t  = s.br ? s.btgt  : s.jdata;
            sl = s.br ? s.bslot : s.jslot;
            if (sl) begin
                m_wslot = 1; m_tgt = t;
            end else begin
                fire = 1; from_tgt = 1; dest = t;
            end
        end else if (s.jr) begin
            m_wdata = 1; m_need_ds = s.jslot; m_ds = 0;
        end
`ifdef IF_REDIRECT_ALIGN_CHECK_EN
        if (fire && from_tgt && dest[1:0] != 2'b00) begin
            fire = 0; m_adel = 1; m_wslot = 0; m_wdata = 0;
        end
`else
        if (fire && from_tgt) m_adel = 0;
`endif
        if (fire) begin
            m_pres = 1; m_pc = dest; m_wslot = 0; m_wdata = 0;
        end
        if (m_pres) rd_q.push_back('{stamp: cyc + 1, pc: m_pc});
        st_q.push_back('{stamp: cyc + 1, busy: (m_pres | m_wslot | m_wdata), adel: m_adel});
    endtask

    task automatic step(input stim_t s);
        @(posedge clk);
        #1;
        bus.exc_req    = s.exc;
        bus.eret_req   = s.eret;
        bus.epc        = s.epc;
        bus.br_valid   = s.br;
        bus.br_slot    = s.bslot;
        bus.br_target  = s.btgt;
        bus.jr_req     = s.jr;
        bus.jr_slot    = s.jslot;
        bus.jr_data_ok = s.jok;
        bus.jr_data    = s.jdata;
        bus.fetch_fire = s.ff;
        bus.if_stall   = s.stall;
        model_step(s);
    endtask

    // Monitor: pops the scoreboard whenever IF is shown a redirect or one is owed
    always @(negedge clk) begin
        rd_t e;
        st_t f;
        if (run) begin
            if (bus.redirect_valid || (rd_q.size() > 0 && rd_q[0].stamp == cyc)) begin
                if (rd_q.size() > 0 && rd_q[0].stamp == cyc) begin
                    e = rd_q.pop_front();
                    chk("redirect_valid", 32'(bus.redirect_valid), 32'd1);
                    chk("redirect_pc", bus.redirect_pc, e.pc);
                    chk("flush_if", 32'(bus.flush_if), 32'd1);
                end else begin
                    chk("redirect_unexpected", 32'(bus.redirect_valid), 32'd0);
                end
            end
            if (st_q.size() > 0 && st_q[0].stamp == cyc) begin
                f = st_q.pop_front();
                chk("busy", 32'(bus.busy), 32'(f.busy));
                chk("adel_req", 32'(bus.adel_req), 32'(f.adel));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s;
        cyc = 0; total = 0; bad = 0; run = 0;
        reset = 1'b1;
        bus.exc_req = 0; bus.eret_req = 0; bus.epc = '0; bus.br_valid = 0; bus.br_slot = 0;
        bus.br_target = '0; bus.jr_req = 0; bus.jr_slot = 0; bus.jr_data_ok = 0; bus.jr_data = '0;
        bus.fetch_fire = 0; bus.if_stall = 0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", 32'(bus.redirect_valid), 32'd0);
        chk("reset_pc", bus.redirect_pc, RST_PC);
        chk("reset_flush", 32'(bus.flush_if), 32'd0);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_adel", 32'(bus.adel_req), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        run = 1;

        // Slot-1 branch: redirect visible for exactly one cycle
        s = idle_stim(); s.br = 1; s.bslot = 0; s.btgt = 32'hBFC0_0100;
        step(s);
        step(idle_stim());
        chk("s1_valid", 32'(bus.redirect_valid), 32'd1);
        chk("s1_pc", bus.redirect_pc, 32'hBFC0_0100);
        step(idle_stim());
        chk("s1_drop", 32'(bus.redirect_valid), 32'd0);

        // Slot-2 branch: waits for the delay-slot bundle
        s = idle_stim(); s.br = 1; s.bslot = 1; s.btgt = 32'h8000_0200;
        step(s);
        step(idle_stim());
        step(idle_stim());
        s = idle_stim(); s.ff = 1;
        step(s);
        chk("s2_not_early", 32'(bus.redirect_valid), 32'd0);
        step(idle_stim());
        chk("s2_valid", 32'(bus.redirect_valid), 32'd1);
        chk("s2_pc", bus.redirect_pc, 32'h8000_0200);
        step(idle_stim());

        // Late jr: delay slot already fetched, data arrives later
        s = idle_stim(); s.jr = 1; s.jslot = 1;
        step(s);
        s = idle_stim(); s.ff = 1;
        step(s);
        step(idle_stim());
        step(idle_stim());
        s = idle_stim(); s.jok = 1; s.jdata = 32'h8000_0040;
        step(s);
        chk("jr_not_early", 32'(bus.redirect_valid), 32'd0);
        step(idle_stim());
        chk("jr_valid", 32'(bus.redirect_valid), 32'd1);
        chk("jr_pc", bus.redirect_pc, 32'h8000_0040);
        step(idle_stim());

        // Stall hold: redirect stays put for three stalled cycles
        s = idle_stim(); s.br = 1; s.btgt = 32'h9000_0010;
        step(s);
        for (int i = 0; i < 3; i++) begin
            s = idle_stim(); s.stall = 1;
            step(s);
            chk("hold_valid", 32'(bus.redirect_valid), 32'd1);
            chk("hold_pc", bus.redirect_pc, 32'h9000_0010);
        end
        step(idle_stim());
        chk("hold_consume_valid", 32'(bus.redirect_valid), 32'd1);
        step(idle_stim());
        chk("hold_drop", 32'(bus.redirect_valid), 32'd0);

        // Exception preempts a branch waiting on its delay slot
        s = idle_stim(); s.br = 1; s.bslot = 1; s.btgt = 32'h8000_2000;
        step(s);
        s = idle_stim(); s.exc = 1;
        step(s);
        step(idle_stim());
        chk("exc_pc", bus.redirect_pc, EXCV);
        s = idle_stim(); s.ff = 1;
        step(s);
        step(idle_stim());
        chk("exc_target_lost", 32'(bus.redirect_valid), 32'd0);
        chk("exc_idle_busy", 32'(bus.busy), 32'd0);
        s = idle_stim(); s.exc = 1; s.eret = 1; s.epc = 32'h8000_3000;
        step(s);
        step(idle_stim());
        chk("exc_over_eret_pc", bus.redirect_pc, EXCV);
        step(idle_stim());

`ifdef IF_REDIRECT_ALIGN_CHECK_EN
        s = idle_stim(); s.br = 1; s.btgt = 32'h0000_0102;
        step(s);
        step(idle_stim());
        chk("align_adel", 32'(bus.adel_req), 32'd1);
        chk("align_no_valid", 32'(bus.redirect_valid), 32'd0);
        step(idle_stim());
        chk("align_adel_pulse", 32'(bus.adel_req), 32'd0);
`endif

        for (int i = 0; i < 3000; i++) begin
            step(rand_stim());
        end
        repeat (4) step(idle_stim());

        // Asynchronous reset while a redirect is presented
        s = idle_stim(); s.br = 1; s.btgt = 32'h8000_1000;
        step(s);
        s = idle_stim(); s.stall = 1;
        step(s);
        chk("pre_reset_valid", 32'(bus.redirect_valid), 32'd1);
        #2;
        run = 0;
        reset = 1'b1;
        #1;
        chk("areset_valid", 32'(bus.redirect_valid), 32'd0);
        chk("areset_pc", bus.redirect_pc, RST_PC);
        chk("areset_flush", 32'(bus.flush_if), 32'd0);
        chk("areset_busy", 32'(bus.busy), 32'd0);
        rd_q.delete();
        st_q.delete();
        model_clear();
        @(negedge clk);
        reset = 1'b0;
        #1;
        run = 1;

        for (int i = 0; i < 500; i++) begin
            step(rand_stim());
        end
        repeat (4) step(idle_stim());
        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 32'(rd_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
